// File: rtl/pcie_phy_pkg.sv
// Shared constants and types for the PCIe PHY lane datapath.
// Used by both the transmit serializer and the receive-side deserializer.
package pcie_phy_pkg;

  localparam int BYTE_W = 8;
  localparam int BIT_CNT_W = 3;
  localparam logic [BYTE_W-1:0] COM_CHAR_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    RESET  = 2'b00,
    IDLE   = 2'b01,
    ACTIVE = 2'b10
  } lane_tx_state_t;

endpackage

// File: rtl/bit_counter_mod8.sv
// Free-running 3-bit bit-slot counter that wraps 7 -> 0.
// Its last flag marks the byte boundary for the serializer and deserializer.
module bit_counter_mod8
  import pcie_phy_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output logic [BIT_CNT_W-1:0] bitCnt,
  output logic                 last
);

  logic [BIT_CNT_W-1:0] cntReg;

  // Count bit slots; natural 3-bit overflow provides the 7 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cntReg <= 3'd0;
    end else begin
      cntReg <= cntReg + 3'd1;
    end
  end

  assign bitCnt = cntReg;
  assign last   = (cntReg == 3'd7);

endmodule

// File: rtl/par_to_serial_lane.sv
// Per-lane byte-to-bit serializer: MSB-first, one byte per 8 clk,
// with COM symbols filling every slot that has no valid byte.
module par_to_serial_lane
  import pcie_phy_pkg::*;
#(
  parameter int                    DATA_WIDTH = BYTE_W,
  parameter logic [DATA_WIDTH-1:0] COM_CHAR   = COM_CHAR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  byte_req,
  output logic                  data_out,
  output logic                  valid_out,
  output logic                  com_out,
  output logic                  active
);

  logic [BIT_CNT_W-1:0]  bitCnt;
  logic                  loadSlot;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic                  kindReg;
  lane_tx_state_t        stateReg;
  lane_tx_state_t        stateNext;

  bit_counter_mod8 uBitCnt (
    .clk    (clk),
    .reset  (reset),
    .bitCnt (bitCnt),
    .last   (loadSlot)
  );

  // Decoded straight from the counter register, so it cannot glitch.
  assign byte_req = loadSlot;

  // Byte holding register: captured only on the byte boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg <= COM_CHAR;
      kindReg  <= 1'b0;
    end else if (loadSlot) begin
      shiftReg <= valid_in ? data_in : COM_CHAR;
      kindReg  <= valid_in;
    end
  end

  // Serial output stage; the old byte's LSB still goes out on the load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= 1'b0;
      valid_out <= 1'b0;
      com_out   <= 1'b0;
    end else begin
      data_out  <= shiftReg[3'd7 - bitCnt];
      valid_out <= kindReg;
      com_out   <= ~kindReg;
    end
  end

  // Next-state logic: data/COM mode only switches on a byte boundary.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RESET: begin
        stateNext = IDLE;
      end
      IDLE: begin
        if (loadSlot && valid_in) begin
          stateNext = ACTIVE;
        end else begin
          stateNext = IDLE;
        end
      end
      ACTIVE: begin
        if (loadSlot && !valid_in) begin
          stateNext = IDLE;
        end else begin
          stateNext = ACTIVE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register and registered active flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= RESET;
      active   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      active   <= (stateNext == ACTIVE);
    end
  end

endmodule

// File: tb/tb_par_to_serial_lane.sv
// Scoreboard bench for par_to_serial_lane: expected bit slots are queued at
// each modelled load edge and compared as the serial stream emerges.
module tb_par_to_serial_lane;

  localparam logic [7:0] TB_COM = 8'hBC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       byte_req;
  logic       data_out;
  logic       valid_out;
  logic       com_out;
  logic       active;

  int nCompared = 0;
  int nMismatched = 0;

  // Model state: bit slot counter, active flag, queued {bit, valid, com}.
  logic [2:0] mCnt = 3'd0;
  logic       mActive = 1'b0;
  logic [2:0] sb[$];

  par_to_serial_lane dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .byte_req  (byte_req),
    .data_out  (data_out),
    .valid_out (valid_out),
    .com_out   (com_out),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushByte(input logic [7:0] d, input logic k);
    for (int i = 7; i >= 0; i--) begin
      sb.push_back({d[i], k, ~k});
    end
  endtask

  // One clock: sample inputs as the DUT sees them, advance the model, compare.
  task automatic tick();
    logic       r;
    logic       v;
    logic [7:0] d;
    logic [2:0] pc;
    logic [2:0] e;
    r  = reset;
    v  = valid_in;
    d  = data_in;
    pc = mCnt;
    @(posedge clk);
    #1;
    if (r) begin
      mCnt    = 3'd0;
      mActive = 1'b0;
      sb.delete();
      pushByte(TB_COM, 1'b0);
      checkValue("rst_data_out", 8'(data_out), 8'd0);
      checkValue("rst_valid_out", 8'(valid_out), 8'd0);
      checkValue("rst_com_out", 8'(com_out), 8'd0);
    end else begin
      checkValue("sb_level", 8'(sb.size() > 0), 8'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkValue("data_out", 8'(data_out), 8'(e[2]));
        checkValue("valid_out", 8'(valid_out), 8'(e[1]));
        checkValue("com_out", 8'(com_out), 8'(e[0]));
      end
      if (pc == 3'd7) begin
        pushByte(v ? d : TB_COM, v);
        mActive = v;
      end
      mCnt = pc + 3'd1;
    end
    checkValue("byte_req", 8'(byte_req), 8'(mCnt == 3'd7));
    checkValue("active", 8'(active), 8'(mActive));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
    end
  endtask

  // Advance until the next edge is a load edge (model counter at 7).
  task automatic alignLoad();
    for (int i = 0; i < 8 && mCnt != 3'd7; i++) begin
      tick();
    end
  endtask

  // Present a byte for exactly one 8-clk slot aligned to byte_req.
  task automatic sendByte(input logic [7:0] d, input logic v);
    alignLoad();
    data_in  = d;
    valid_in = v;
    ticks(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held 5 clk, then idle COM stream.
    reset = 1'b1;
    ticks(5);
    reset = 1'b0;
    valid_in = 1'b0;
    ticks(20);

    // Single valid byte.
    sendByte(8'hA5, 1'b1);
    valid_in = 1'b0;
    ticks(16);

    // Back-to-back valid bytes, then a drop to COM.
    sendByte(8'h01, 1'b1);
    sendByte(8'hFF, 1'b1);
    sendByte(8'h80, 1'b1);
    sendByte(8'h3C, 1'b1);
    sendByte(8'h00, 1'b0);
    ticks(10);

    // Reset in the middle of a byte.
    alignLoad();
    data_in  = 8'hA5;
    valid_in = 1'b1;
    ticks(4);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    valid_in = 1'b0;
    ticks(20);

    // Short valid pulse that misses byte_req.
    alignLoad();
    tick();
    ticks(2);
    data_in  = 8'hFF;
    valid_in = 1'b1;
    ticks(2);
    valid_in = 1'b0;
    ticks(14);

    // Random mix of valid and COM slots.
    for (int i = 0; i < 8; i++) begin
      sendByte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    valid_in = 1'b0;
    ticks(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/par_to_serial_lane.md
# par_to_serial_lane

Per-lane parallel-to-serial transmitter, placed directly downstream of the 1x2 8-bit lane demux. It takes one lane's byte stream (8-bit data plus valid) and shifts it out MSB-first as a 1-bit serial stream on the lane's bit clock. When the lane has no valid byte, it substitutes the COM symbol so the link never goes silent. Two instances, one per demux output, form the serializer front end of the physical layer.

## Interface
- `DATA_WIDTH`, 8, byte width; fixed at 8, the only supported value
- `COM_CHAR`, 8'hBC, symbol transmitted in any byte slot where no valid byte is present
- `clk` in 1: bit clock, 8x the lane byte rate, single clock domain
- `reset` in 1: synchronous, active-high
- `data_in` in 8: lane byte, from the demux `data_out0` / `data_out1`
- `valid_in` in 1: qualifies `data_in`, from the demux `outValid0` / `outValid1`
- `byte_req` out 1: high in the single cycle in which `data_in` / `valid_in` are sampled
- `data_out` out 1: serial bit, MSB first
- `valid_out` out 1: high while `data_out` carries a bit of a valid byte
- `com_out` out 1: high while `data_out` carries a bit of an inserted COM symbol
- `active` out 1: FSM is in ACTIVE

## Operation
- 3-bit `bit_cnt` increments every cycle and wraps 7 -> 0. `byte_req = (bit_cnt == 7)`, decoded from the register, so it is glitch-free.
- Load: on the edge where `bit_cnt == 7`:
  - `shreg <= valid_in ? data_in : COM_CHAR`
  - `kind <= valid_in`
  - No other cycle samples the inputs. Upstream holds each byte stable for 8 clk. A valid pulse shorter than 8 clk is honoured only if it covers the `byte_req` cycle.
- Shift: every non-reset edge:
  - `data_out <= shreg[7 - bit_cnt]`
  - `valid_out <= kind`
  - `com_out <= ~kind`
- FSM states:
  - RESET: occupied only while `reset` is asserted.
  - IDLE: sending COM.
  - ACTIVE: sending data.
- FSM transitions:
  - RESET -> IDLE on the first edge with `reset` low.
  - IDLE -> ACTIVE on a load edge with `valid_in = 1`.
  - ACTIVE -> IDLE on a load edge with `valid_in = 0`.
  - `active` is registered and changes on the load edge.
- Reset values (`reset` high at an edge):
  - `bit_cnt = 0`, `shreg = COM_CHAR`, `kind = 0`
  - `data_out = 0`, `valid_out = 0`, `com_out = 0`, `active = 0`, state RESET
  - `byte_req` is 0, because it is decoded from `bit_cnt = 0`.
- Reset asserted mid-byte: the partial byte is abandoned and never resumed. After release, the first slot is a full COM_CHAR starting at bit 7.
- Back-to-back valid bytes are sent with no gap. Valid/invalid changes take effect only on byte boundaries.

## Timing
- Load edge E (`bit_cnt == 7`): the MSB of the loaded byte appears on `data_out` after edge E+1. The LSB appears after E+8.
- `valid_out` / `com_out` are aligned with the bits of the same byte and are constant across all 8 bits.
- After reset release at edge R (first edge with `reset` low):
  - `data_out` shows COM_CHAR bit 7 after R. COM_CHAR is sent over cycles R..R+7.
  - `bit_cnt` reaches 7 in the cycle after edge R+6, so `byte_req` is high then.
  - The first sample happens at edge R+7.
  - The first sampled byte's MSB is on `data_out` after R+8.
- Throughput: one byte per 8 clk, sustained.
- Simultaneous `reset` and load: reset wins and the byte is dropped.

## Structure
- Shared package `pcie_phy_pkg`:
  - `COM_CHAR_DEFAULT = 8'hBC`
  - FSM state typedef `lane_tx_state_t` {RESET, IDLE, ACTIVE}
  - `BYTE_W = 8`
- Sub-module `bit_counter_mod8`:
  - 3-bit wrap counter with sync reset.
  - Provides `bit_cnt` and `last` (== 7).
  - Reusable by the receive-side deserializer.

## Test plan
- Reset held 5 clk, then released with `valid_in = 0` -> COM pattern 1,0,1,1,1,1,0,0 repeats on `data_out`; `com_out = 1`, `valid_out = 0`, `active = 0`.
- `data_in = 8'hA5`, `valid_in = 1` held through one `byte_req` -> serial 1,0,1,0,0,1,0,1 starting 1 clk after the load edge; `valid_out` high for exactly those 8 bits; `active` rises at the load edge.
- Bytes 8'h01, 8'hFF, 8'h80 back-to-back, each valid for 8 clk aligned to `byte_req` -> 24 contiguous bits with `valid_out` continuously high and no COM inserted.
- `valid_in` drops after 8'h3C -> the next slot is COM_CHAR (`com_out = 1`) and `active` falls at that load edge.
- `reset` asserted at `bit_cnt = 3` during 8'hA5 -> outputs are 0 next cycle; after release a full COM_CHAR is sent before any data.
- `valid_in` pulsed for 2 clk not covering `byte_req` -> the pulse is ignored and COM is sent.
